// File: rtl/game_pkg.sv
// game_pkg: types and constants shared by the line sequencer, board store
// and line_writer (row geometry, line_writer FSM states, row-select helper).
package game_pkg;

  localparam int ROW_WIDTH = 8;   // bits per board row
  localparam int NUM_LINES = 8;   // rows on the board
  localparam int LINE_W    = 3;   // width of a row index
  localparam int DIV_W     = 8;   // width of the serial-clock divider counter

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    LATCH = 3'd3,
    DONE  = 3'd4
  } state_t;

  // One-hot row drive for row index 'line' (bit n lights row n).
  function automatic logic [ROW_WIDTH-1:0] row_onehot(input logic [LINE_W-1:0] line);
    logic [ROW_WIDTH-1:0] one;
    one        = {{(ROW_WIDTH-1){1'b0}}, 1'b1};
    row_onehot = one << line;
  endfunction

endpackage

// File: rtl/line_writer_bit_timer.sv
// bit_timer: serial-clock half-period timer for line_writer.
// Down-counter reloading to CLK_DIV-1; 'tick' is high in the last cycle of
// each CLK_DIV-cycle half period. 'restart' realigns the count so the first
// tick comes CLK_DIV cycles after the restart edge.
module bit_timer
  import game_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam logic [DIV_W-1:0] RELOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] ZERO   = {DIV_W{1'b0}};

  logic [DIV_W-1:0] count_r;

  // Half-period down-counter, reloaded on restart or when it expires.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= ZERO;
    end else if (restart || (count_r == ZERO)) begin
      count_r <= RELOAD;
    end else begin
      count_r <= count_r - DIV_W'(1);
    end
  end

  assign tick = (count_r == ZERO);

endmodule

// File: rtl/line_writer.sv
// line_writer: serialises one board row to the LED column shift register,
// latches it, drives the one-hot row select and pulses 'update' so the
// sequencer advances 'lineNum'.
// Build option: define LINE_WRITER_BLANK_EN to blank 'rowSel' from LOAD
// until LATCH (anti-ghosting); otherwise the previous row stays lit until
// the new row is latched.
// CLK_DIV (1..255) is the number of clk cycles per serial-clock half period.
module line_writer
  import game_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [LINE_W-1:0]    lineNum,
  input  logic [ROW_WIDTH-1:0] rowData,
  output logic                 update,
  output logic                 serData,
  output logic                 serClk,
  output logic                 latch,
  output logic [ROW_WIDTH-1:0] rowSel
);

  state_t               state_r, state_nxt_s;
  logic [LINE_W-1:0]    line_r, line_nxt_s;
  logic [ROW_WIDTH-1:0] shift_r, shift_nxt_s;
  logic [2:0]           bit_cnt_r, bit_cnt_nxt_s;
  logic                 half_r, half_nxt_s;        // 0: serClk low phase, 1: high phase
  logic                 ser_clk_r, ser_clk_nxt_s;
  logic                 latch_r, latch_nxt_s;
  logic                 update_r, update_nxt_s;
  logic [ROW_WIDTH-1:0] row_sel_r, row_sel_nxt_s;
  logic                 restart_s;
  logic                 tick_s;
  logic                 bit_end_s;
  logic                 last_bit_s;

  bit_timer #(.CLK_DIV(CLK_DIV)) u_bit_timer (
    .clk     (clk),
    .rst     (rst),
    .restart (restart_s),
    .tick    (tick_s)
  );

  // A bit ends when its high phase expires; the row ends after bit count 7.
  assign bit_end_s  = tick_s && half_r;
  assign last_bit_s = bit_end_s && (bit_cnt_r == 3'd7);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; enable is only looked at in IDLE so a row never aborts.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (enable) begin
          state_nxt_s = LOAD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOAD: begin
        state_nxt_s = SHIFT;
      end
      SHIFT: begin
        if (last_bit_s) begin
          state_nxt_s = LATCH;
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      LATCH: begin
        if (tick_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = LATCH;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Output/datapath next values; every output is a register loaded from here.
  always_comb begin
    line_nxt_s    = line_r;
    shift_nxt_s   = shift_r;
    bit_cnt_nxt_s = bit_cnt_r;
    half_nxt_s    = half_r;
    ser_clk_nxt_s = ser_clk_r;
    latch_nxt_s   = latch_r;
    update_nxt_s  = 1'b0;
    row_sel_nxt_s = row_sel_r;
    restart_s     = 1'b0;
    case (state_r)
      IDLE: begin
        ser_clk_nxt_s = 1'b0;
        latch_nxt_s   = 1'b0;
        if (enable) begin
          line_nxt_s = lineNum;
`ifdef LINE_WRITER_BLANK_EN
          row_sel_nxt_s = {ROW_WIDTH{1'b0}};
`else
          row_sel_nxt_s = row_sel_r;
`endif
        end else begin
          line_nxt_s = line_r;
        end
      end
      LOAD: begin
        shift_nxt_s   = rowData;
        bit_cnt_nxt_s = 3'd0;
        half_nxt_s    = 1'b0;
        restart_s     = 1'b1;     // first low phase starts on SHIFT entry
      end
      SHIFT: begin
        if (tick_s && !half_r) begin
          half_nxt_s    = 1'b1;
          ser_clk_nxt_s = 1'b1;
        end else if (bit_end_s) begin
          // serData changes together with the falling serClk edge.
          half_nxt_s    = 1'b0;
          ser_clk_nxt_s = 1'b0;
          shift_nxt_s   = {shift_r[ROW_WIDTH-2:0], 1'b0};
          bit_cnt_nxt_s = bit_cnt_r + 3'd1;
          if (last_bit_s) begin
            restart_s     = 1'b1; // latch pulse is timed from LATCH entry
            latch_nxt_s   = 1'b1;
            row_sel_nxt_s = row_onehot(line_r);
          end else begin
            latch_nxt_s   = 1'b0;
          end
        end else begin
          half_nxt_s = half_r;
        end
      end
      LATCH: begin
        if (tick_s) begin
          latch_nxt_s  = 1'b0;
          update_nxt_s = 1'b1;
        end else begin
          latch_nxt_s  = 1'b1;
        end
      end
      DONE: begin
        update_nxt_s = 1'b0;
      end
      default: begin
        update_nxt_s = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_r    <= {LINE_W{1'b0}};
      shift_r   <= {ROW_WIDTH{1'b0}};
      bit_cnt_r <= 3'd0;
      half_r    <= 1'b0;
      ser_clk_r <= 1'b0;
      latch_r   <= 1'b0;
      update_r  <= 1'b0;
      row_sel_r <= {ROW_WIDTH{1'b0}};
    end else begin
      line_r    <= line_nxt_s;
      shift_r   <= shift_nxt_s;
      bit_cnt_r <= bit_cnt_nxt_s;
      half_r    <= half_nxt_s;
      ser_clk_r <= ser_clk_nxt_s;
      latch_r   <= latch_nxt_s;
      update_r  <= update_nxt_s;
      row_sel_r <= row_sel_nxt_s;
    end
  end

  // serData is the MSB of the shift register, so it is itself a flop output.
  assign serData = shift_r[ROW_WIDTH-1];
  assign serClk  = ser_clk_r;
  assign latch   = latch_r;
  assign update  = update_r;
  assign rowSel  = row_sel_r;

endmodule

// File: tb/tb_line_writer.sv
// tb_line_writer: directed bench for line_writer with two instances,
// CLK_DIV=4 (u_dut4) and CLK_DIV=1 (u_dut1). Serial bits are captured on
// each serClk rising edge; outputs are sampled on the falling clk edge.
module tb_line_writer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en4 = 1'b0;
  logic       en1 = 1'b0;
  logic [2:0] line_num = 3'd0;
  logic [7:0] row_data = 8'h00;

  logic       upd4, sd4, sc4, lat4;
  logic [7:0] rs4;
  logic       upd1, sd1, sc1, lat1;
  logic [7:0] rs1;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Count rising clk edges; after edge k, cyc == k.
  always @(posedge clk) cyc <= cyc + 1;

  line_writer #(.CLK_DIV(4)) u_dut4 (
    .clk(clk), .rst(rst), .enable(en4), .lineNum(line_num), .rowData(row_data),
    .update(upd4), .serData(sd4), .serClk(sc4), .latch(lat4), .rowSel(rs4)
  );

  line_writer #(.CLK_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .enable(en1), .lineNum(line_num), .rowData(row_data),
    .update(upd1), .serData(sd1), .serClk(sc1), .latch(lat1), .rowSel(rs1)
  );

  // Monitor: serial capture on serClk rise, pulse/high-cycle counters.
  logic        sc4_prev = 1'b0, sc1_prev = 1'b0;
  logic [63:0] cap4 = 64'd0, cap1 = 64'd0;
  int cap4_cnt = 0, cap1_cnt = 0, upd4_cnt = 0, upd1_cnt = 0;
  int lat4_cnt = 0, lat1_cnt = 0, hi1_cnt = 0;

  always @(negedge clk) begin
    sc4_prev <= sc4;
    sc1_prev <= sc1;
    if (sc4 && !sc4_prev) begin
      cap4     <= {cap4[62:0], sd4};
      cap4_cnt <= cap4_cnt + 1;
    end
    if (sc1 && !sc1_prev) begin
      cap1     <= {cap1[62:0], sd1};
      cap1_cnt <= cap1_cnt + 1;
    end
    if (upd4) upd4_cnt <= upd4_cnt + 1;
    if (upd1) upd1_cnt <= upd1_cnt + 1;
    if (lat4) lat4_cnt <= lat4_cnt + 1;
    if (lat1) lat1_cnt <= lat1_cnt + 1;
    if (sc1)  hi1_cnt  <= hi1_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_upd4(input int max_cyc, output int at, output logic ok);
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (upd4) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
  endtask

  task automatic wait_upd1(input int max_cyc, output int at, output logic ok);
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (upd1) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
  endtask

  task automatic wait_cyc(input int target);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (cyc >= target) break;
    end
  endtask

  // One-cycle enable pulse to u_dut4; e0 is the edge that samples it.
  task automatic pulse4(output int e0);
    @(negedge clk);
    en4 = 1'b1;
    @(posedge clk);
    #1;
    e0  = cyc;
    en4 = 1'b0;
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         e0, at, prev, c0, u0, l0, h0;
    logic       ok;
    logic [7:0] pat [8];
    logic [7:0] exp_sel;
    pat[0] = 8'h01; pat[1] = 8'h3C; pat[2] = 8'hF0; pat[3] = 8'h0F;
    pat[4] = 8'hC3; pat[5] = 8'h5A; pat[6] = 8'hFF; pat[7] = 8'h00;

    // Reset state.
    repeat (3) @(negedge clk);
    check_eq("rst_ctl4", {28'd0, upd4, sd4, sc4, lat4}, 32'd0);
    check_eq("rst_sel4", {24'd0, rs4}, 32'h00);
    check_eq("rst_ctl1", {28'd0, upd1, sd1, sc1, lat1}, 32'd0);
    check_eq("rst_sel1", {24'd0, rs1}, 32'h00);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single row A5 on line 3, enable pulsed for one cycle.
    line_num = 3'd3;
    row_data = 8'hA5;
    c0 = cap4_cnt; u0 = upd4_cnt; l0 = lat4_cnt;
    pulse4(e0);
    wait_upd4(200, at, ok);
    check_eq("a5_update_seen", {31'd0, ok}, 32'd1);
    check_eq("a5_latency", at - e0, 32'd69);
    check_eq("a5_rowsel", {24'd0, rs4}, 32'h08);
    repeat (5) @(negedge clk);
    check_eq("a5_nbits", cap4_cnt - c0, 32'd8);
    check_eq("a5_bits", {24'd0, cap4[7:0]}, 32'hA5);
    check_eq("a5_npulse", upd4_cnt - u0, 32'd1);
    check_eq("a5_latch_cycles", lat4_cnt - l0, 32'd4);

    // Sequencer model: enable held, lineNum advanced on each update.
    // Pulses are 71 edges apart, i.e. 70 cycles lie between two pulses.
    @(negedge clk);
    line_num = 3'd0;
    row_data = pat[0];
    en4 = 1'b1;
    u0 = upd4_cnt;
    @(posedge clk);
    #1;
    e0 = cyc;
    prev = 0;
    for (int r = 0; r < 8; r++) begin
      wait_upd4(200, at, ok);
      check_eq($sformatf("seq%0d_seen", r), {31'd0, ok}, 32'd1);
      exp_sel = 8'h01 << r;
      check_eq($sformatf("seq%0d_rowsel", r), {24'd0, rs4}, {24'd0, exp_sel});
      check_eq($sformatf("seq%0d_bits", r), {24'd0, cap4[7:0]}, {24'd0, pat[r]});
      if (r == 0) check_eq("seq0_latency", at - e0, 32'd69);
      else        check_eq($sformatf("seq%0d_spacing", r), at - prev, 32'd71);
      prev = at;
      if (r < 7) begin
        line_num = 3'(r + 1);
        row_data = pat[r + 1];
      end else begin
        en4 = 1'b0;
      end
    end
    repeat (150) @(negedge clk);
    check_eq("seq_npulse", upd4_cnt - u0, 32'd8);

    // Asynchronous reset during SHIFT bit 4, then a fresh row.
    line_num = 3'd6;
    row_data = 8'hFF;
    c0 = cap4_cnt; u0 = upd4_cnt;
    pulse4(e0);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cap4_cnt - c0 >= 5) break;
    end
    check_eq("abort_pre_clk", {31'd0, sc4}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_eq("abort_ctl", {28'd0, upd4, sd4, sc4, lat4}, 32'd0);
    check_eq("abort_rowsel", {24'd0, rs4}, 32'h00);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (100) @(negedge clk);
    check_eq("abort_no_update", upd4_cnt - u0, 32'd0);
    line_num = 3'd1;
    row_data = 8'h96;
    c0 = cap4_cnt;
    pulse4(e0);
    wait_upd4(200, at, ok);
    check_eq("restart_latency", at - e0, 32'd69);
    check_eq("restart_rowsel", {24'd0, rs4}, 32'h02);
    repeat (5) @(negedge clk);
    check_eq("restart_nbits", cap4_cnt - c0, 32'd8);
    check_eq("restart_bits", {24'd0, cap4[7:0]}, 32'h96);

    // Inputs changed after capture are ignored; enable already low.
    line_num = 3'd4;
    row_data = 8'h3A;
    c0 = cap4_cnt; u0 = upd4_cnt;
    pulse4(e0);
    repeat (10) @(negedge clk);
    row_data = 8'hFF;
    line_num = 3'd7;
    wait_upd4(200, at, ok);
    check_eq("hold_latency", at - e0, 32'd69);
    check_eq("hold_rowsel", {24'd0, rs4}, 32'h10);
    repeat (100) @(negedge clk);
    check_eq("hold_bits", {24'd0, cap4[7:0]}, 32'h3A);
    check_eq("hold_npulse", upd4_cnt - u0, 32'd1);

    // CLK_DIV=1: serClk toggles every cycle, update 18 edges after sampling.
    line_num = 3'd2;
    row_data = 8'h80;
    c0 = cap1_cnt; u0 = upd1_cnt; l0 = lat1_cnt; h0 = hi1_cnt;
    @(negedge clk);
    en1 = 1'b1;
    @(posedge clk);
    #1;
    e0  = cyc;
    en1 = 1'b0;
    wait_upd1(60, at, ok);
    check_eq("div1_latency", at - e0, 32'd18);
    check_eq("div1_rowsel", {24'd0, rs1}, 32'h04);
    repeat (5) @(negedge clk);
    check_eq("div1_nbits", cap1_cnt - c0, 32'd8);
    check_eq("div1_bits", {24'd0, cap1[7:0]}, 32'h80);
    check_eq("div1_high_cycles", hi1_cnt - h0, 32'd8);
    check_eq("div1_latch_cycles", lat1_cnt - l0, 32'd1);
    check_eq("div1_npulse", upd1_cnt - u0, 32'd1);

    // Row 2 then row 5: rowSel through LOAD/SHIFT depends on blanking build.
    line_num = 3'd2;
    row_data = 8'h11;
    pulse4(e0);
    wait_upd4(200, at, ok);
    check_eq("r2_rowsel", {24'd0, rs4}, 32'h04);
    repeat (3) @(negedge clk);
    line_num = 3'd5;
    row_data = 8'h69;
    pulse4(e0);
    wait_cyc(e0);
`ifdef LINE_WRITER_BLANK_EN
    check_eq("r5_rowsel_load", {24'd0, rs4}, 32'h00);
`else
    check_eq("r5_rowsel_load", {24'd0, rs4}, 32'h04);
`endif
    wait_cyc(e0 + 64);
`ifdef LINE_WRITER_BLANK_EN
    check_eq("r5_rowsel_shift_end", {24'd0, rs4}, 32'h00);
`else
    check_eq("r5_rowsel_shift_end", {24'd0, rs4}, 32'h04);
`endif
    check_eq("r5_latch_before", {31'd0, lat4}, 32'd0);
    wait_cyc(e0 + 65);
    check_eq("r5_rowsel_latch", {24'd0, rs4}, 32'h20);
    check_eq("r5_latch_on", {31'd0, lat4}, 32'd1);
    wait_cyc(e0 + 69);
    check_eq("r5_done", {30'd0, upd4, lat4}, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
